nv_nvdla_sdp_wdma_split: RTL

//  Transmit-side counterpart of the SDP RDMA atom packer. Accepts one wide word of ATOM_NUM

---
 rtl/nv_nvdla_sdp_pkg.sv | 15 +
 rtl/nv_nvdla_sdp_split_ffs.sv | 32 +++
 rtl/nv_nvdla_sdp_wdma_split.sv | 96 +++++++++
 3 files changed

// File: rtl/nv_nvdla_sdp_pkg.sv
// Shared SDP constants so the RDMA packer and the WDMA splitter agree on atom geometry.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
package nv_nvdla_sdp_pkg;

  localparam int SDP_ATOM_DW  = 256;
  localparam int SDP_ATOM_NUM = 4;
  localparam int SDP_WIDE_DW  = SDP_ATOM_NUM * SDP_ATOM_DW;

  // Width of an atom index; a single-atom word still needs a 1-bit index.
  function automatic int sdp_sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nv_nvdla_sdp_split_ffs.sv
// Find-first-set over the remaining-atom mask: lowest set index, its onehot, single-bit flag.
// Latency: purely combinational.
// Backpressure: none; follows the mask register directly.
module nv_nvdla_sdp_split_ffs
  import nv_nvdla_sdp_pkg::*;
#(
  parameter int N = SDP_ATOM_NUM,
  localparam int SW = sdp_sel_w(N)
) (
  input  logic [N-1:0]  i_mask,
  output logic [SW-1:0] o_sel,
  output logic [N-1:0]  o_onehot,
  output logic          o_single
);

  // Scan high to low so the lowest set bit is the one that sticks.
  always_comb begin
    o_sel    = '0;
    o_onehot = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_sel       = SW'(i);
        o_onehot    = '0;
        o_onehot[i] = 1'b1;
      end
    end
  end

  // Exactly one bit set: nonzero and clearing the lowest bit leaves nothing.
  assign o_single = (i_mask != '0) && ((i_mask & (i_mask - N'(1))) == '0);

endmodule

// File: rtl/nv_nvdla_sdp_wdma_split.sv
// Splits a wide word of masked atoms into one atom per beat, ascending, skipping unset atoms.
// Latency: first beat valid 1 cycle after word accept; 1 atom/cycle sustained.
// Backpressure: out_prdy=0 freezes the held beat; a new word is taken only as the end beat retires.
module nv_nvdla_sdp_wdma_split
  import nv_nvdla_sdp_pkg::*;
#(
  parameter int ATOM_DW  = SDP_ATOM_DW,
  parameter int ATOM_NUM = SDP_ATOM_NUM
) (
  input  logic                                nvdla_core_clk,
  input  logic                                nvdla_core_rstn,
  input  logic                                inp_pvld,
  output logic                                inp_prdy,
  input  logic [ATOM_NUM*ATOM_DW+ATOM_NUM-1:0] inp_data,
  output logic                                out_pvld,
  input  logic                                out_prdy,
  output logic [ATOM_DW:0]                    out_data,
  output logic                                out_end,
  output logic                                split_idle
);

  localparam int WD = ATOM_NUM * ATOM_DW;
  localparam int SW = sdp_sel_w(ATOM_NUM);

  logic                r_hold_vld;
  logic [ATOM_NUM-1:0] r_rem_mask;
  logic [WD-1:0]       r_hold_data;

  logic [ATOM_NUM-1:0] w_in_mask;
  logic [WD-1:0]       w_in_atoms;
  logic [SW-1:0]       w_sel;
  logic [ATOM_NUM-1:0] w_onehot;
  logic                w_single;
  logic                w_out_acc;
  logic                w_end;
  logic                w_inp_acc;
  logic                w_load;
  logic [ATOM_DW-1:0]  w_atom;

  assign w_in_mask  = inp_data[WD +: ATOM_NUM];
  assign w_in_atoms = inp_data[WD-1:0];

  nv_nvdla_sdp_split_ffs #(.N(ATOM_NUM)) u_ffs (
    .i_mask   (r_rem_mask),
    .o_sel    (w_sel),
    .o_onehot (w_onehot),
    .o_single (w_single)
  );

  assign w_end     = r_hold_vld & w_single;
  assign w_out_acc = r_hold_vld & out_prdy;
  // A new word may enter only when nothing is held or the last held atom leaves this cycle.
  assign inp_prdy  = ~r_hold_vld | (w_out_acc & w_end);
  assign w_inp_acc = inp_pvld & inp_prdy;
  // An all-zero mask word is consumed without ever occupying the hold register.
  assign w_load    = w_inp_acc & (w_in_mask != '0);

  // Control state: load wins over retire; otherwise retire the emitted atom.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_hold_vld <= 1'b0;
      r_rem_mask <= '0;
    end else if (w_inp_acc) begin
      r_hold_vld <= w_load;
      r_rem_mask <= w_load ? w_in_mask : '0;
    end else if (w_out_acc) begin
      if (w_end) begin
        r_hold_vld <= 1'b0;
        r_rem_mask <= '0;
      end else begin
        r_rem_mask[w_sel] <= 1'b0;
      end
    end
  end

  // Atom payload is qualified by r_hold_vld, so it needs no reset.
  always_ff @(posedge nvdla_core_clk) begin
    if (w_load) begin
      r_hold_data <= w_in_atoms;
    end
  end

  // Onehot AND-OR mux of the held atoms; yields zero when nothing is selected.
  always_comb begin
    w_atom = '0;
    for (int i = 0; i < ATOM_NUM; i++) begin
      w_atom = w_atom | (r_hold_data[i*ATOM_DW +: ATOM_DW] & {ATOM_DW{w_onehot[i]}});
    end
  end

  assign out_pvld   = r_hold_vld;
  assign out_data   = {r_hold_vld, w_atom};
  assign out_end    = w_end;
  assign split_idle = ~r_hold_vld;

endmodule
